// File: rtl/seq_func_pkg.sv
// Shared types for the sequential function evaluator: request modes and FSM states.
package seq_func_pkg;

    typedef enum logic [1:0] {
        ModeQuad = 2'd0,
        ModeFact = 2'd1,
        ModeInvq = 2'd2,
        ModeRsvd = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/quad_eval.sv
// Combinational a*x^2 + b*x + c on a signed x, evaluated wide and wrapped to W_Y bits.
module quad_eval #(
    parameter int unsigned W_X = 4,
    parameter int unsigned W_Y = 8,
    parameter int          A   = 1,
    parameter int          B   = 10,
    parameter int          C   = -10
) (
    input  logic [W_X-1:0] x,
    output logic [W_Y-1:0] q
);

    localparam int unsigned WI = 2 * W_Y + W_X;

    logic signed [W_X-1:0] x_s;
    logic signed [WI-1:0]  x_w;
    logic signed [WI-1:0]  a_w;
    logic signed [WI-1:0]  b_w;
    logic signed [WI-1:0]  c_w;

    always_comb begin
        x_s = x;
        x_w = WI'(x_s);
        a_w = WI'(A);
        b_w = WI'(B);
        c_w = WI'(C);
        // Low bits of the wide sum are the wrapped result.
        q   = W_Y'(a_w * x_w * x_w + b_w * x_w + c_w);
    end

endmodule

// File: rtl/seq_func_unit.sv
// Handshaked function evaluator: quadratic, factorial, and inverse quadratic by sweep.
module seq_func_unit
    import seq_func_pkg::*;
#(
    parameter int unsigned W_X = 4,
    parameter int unsigned W_Y = 8,
    parameter int          A   = 1,
    parameter int          B   = 10,
    parameter int          C   = -10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_mode,
    input  logic [W_X-1:0] in_x,
    input  logic [W_Y-1:0] in_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W_Y-1:0] out_data,
    output logic [1:0]     out_mode,
    output logic           out_err
);

    localparam int unsigned WC = W_X + 1;
    localparam int unsigned WE = W_Y + 1;
    localparam logic [WC-1:0] SweepLen = {1'b1, {W_X{1'b0}}};
    localparam logic [WE-1:0] ErrInit  = {1'b1, {W_Y{1'b0}}};

    state_e         state_q, state_d;
    mode_e          mode_q, mode_d;
    logic [W_X-1:0] x_q, x_d;
    logic [W_Y-1:0] y_q, y_d;
    logic [WC-1:0]  cnt_q, cnt_d;
    logic [WC-1:0]  len_q, len_d;
    logic [W_Y-1:0] acc_q, acc_d;
    logic [WE-1:0]  min_err_q, min_err_d;
    logic [W_X-1:0] best_x_q, best_x_d;
    logic           out_valid_q, out_valid_d;
    logic [W_Y-1:0] out_data_q, out_data_d;
    logic [1:0]     out_mode_q, out_mode_d;
    logic           out_err_q, out_err_d;

    logic [W_X-1:0]        sweep_x;
    logic [W_X-1:0]        quad_x;
    logic [W_Y-1:0]        quad_q;
    logic [WE-1:0]         diff;
    logic [WE-1:0]         abs_err;
    logic                  better;
    logic [WE-1:0]         min_err_nxt;
    logic [W_X-1:0]        best_x_nxt;
    logic signed [W_X-1:0] best_x_s;
    logic [W_X-1:0]        fact_k;
    logic [W_Y-1:0]        acc_nxt;
    logic                  calc_last;

    // Sweep counter offset by -2**(W_X-1): flipping the top bit maps 0..2**W_X-1 onto x.
    assign sweep_x = {~cnt_q[W_X-1], cnt_q[W_X-2:0]};
    assign quad_x  = (mode_q == ModeInvq) ? sweep_x : x_q;

    quad_eval #(
        .W_X (W_X),
        .W_Y (W_Y),
        .A   (A),
        .B   (B),
        .C   (C)
    ) u_quad_eval (
        .x (quad_x),
        .q (quad_q)
    );

    always_comb begin
        diff        = {y_q[W_Y-1], y_q} - {quad_q[W_Y-1], quad_q};
        abs_err     = diff[WE-1] ? (~diff + WE'(1)) : diff;
        better      = abs_err < min_err_q;
        min_err_nxt = better ? abs_err : min_err_q;
        best_x_nxt  = better ? sweep_x : best_x_q;
        best_x_s    = best_x_nxt;
        // Multiplier k counts down from n; cycles past k=2 leave the product alone.
        fact_k      = x_q - cnt_q[W_X-1:0];
        acc_nxt     = (fact_k >= W_X'(2)) ? acc_q * W_Y'(fact_k) : acc_q;
        calc_last   = (cnt_q == len_q - WC'(1));
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        acc_d      = acc_q;
        min_err_d  = min_err_q;
        best_x_d   = best_x_q;
        out_data_d = out_data_q;
        out_mode_d = out_mode_q;
        out_err_d  = out_err_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d   = StCalc;
                    mode_d    = mode_e'(in_mode);
                    x_d       = in_x;
                    y_d       = in_y;
                    cnt_d     = '0;
                    acc_d     = W_Y'(1);
                    min_err_d = ErrInit;
                    best_x_d  = '0;
                    case (mode_e'(in_mode))
                        ModeFact: len_d = (in_x > W_X'(2)) ? WC'(in_x) - WC'(1) : WC'(1);
                        ModeInvq: len_d = SweepLen;
                        default:  len_d = WC'(1);
                    endcase
                end
            end
            StCalc: begin
                cnt_d     = cnt_q + WC'(1);
                acc_d     = acc_nxt;
                min_err_d = min_err_nxt;
                best_x_d  = best_x_nxt;
                if (calc_last) begin
                    state_d    = StDone;
                    out_mode_d = mode_q;
                    out_err_d  = (mode_q == ModeRsvd);
                    case (mode_q)
                        ModeQuad: out_data_d = quad_q;
                        ModeFact: out_data_d = acc_nxt;
                        ModeInvq: out_data_d = W_Y'(best_x_s);
                        default:  out_data_d = '0;
                    endcase
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mode_q      <= ModeQuad;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            min_err_q   <= '0;
            best_x_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            min_err_q   <= min_err_d;
            best_x_q    <= best_x_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_seq_func_unit.sv
// Bench for seq_func_unit: integer reference model checked every cycle plus directed literal cases.
module tb_seq_func_unit;

    localparam int A = 1;
    localparam int B = 10;
    localparam int C = -10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_mode = 2'd0;
    logic [3:0] in_x = 4'd0;
    logic [7:0] in_y = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [1:0] out_mode;
    logic       out_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_func_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode),
        .out_err   (out_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model in plain integers ----------------
    function automatic int wrap8(input int v);
        int r;
        r = v & 255;
        return (r >= 128) ? r - 256 : r;
    endfunction

    function automatic int quad_ref(input int x);
        return wrap8(A * x * x + B * x + C);
    endfunction

    function automatic int fact_ref(input int n);
        int acc;
        acc = 1;
        for (int k = n; k >= 2; k--) acc = (acc * k) % 256;
        return acc;
    endfunction

    function automatic int invq_ref(input int y);
        int best;
        int min_e;
        int e;
        best  = -8;
        min_e = 256;
        for (int x = -8; x <= 7; x++) begin
            e = y - quad_ref(x);
            if (e < 0) e = -e;
            if (e < min_e) begin
                min_e = e;
                best  = x;
            end
        end
        return best;
    endfunction

    function automatic int latency(input int mode, input int n);
        if (mode == 1) return (n - 1 > 1) ? n - 1 : 1;
        if (mode == 2) return 16;
        return 1;
    endfunction

    logic       m_ok = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    int         m_left = 0;
    logic [7:0] m_data = 8'd0;
    logic [1:0] m_mode = 2'd0;
    logic       m_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ok   = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_ok) begin
            if (m_done) begin
                if (out_ready) m_done = 1'b0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (in_valid) begin
                m_mode = in_mode;
                m_err  = (in_mode == 2'd3);
                case (in_mode)
                    2'd0: m_data = 8'(quad_ref($signed(in_x)));
                    2'd1: m_data = 8'(fact_ref(int'(in_x)));
                    2'd2: m_data = 8'(invq_ref($signed(in_y)));
                    default: m_data = 8'd0;
                endcase
                m_left = latency(int'(in_mode), int'(in_x));
                m_busy = 1'b1;
            end
        end
        #1;
        if (m_ok) begin
            chk("model in_ready", 32'(in_ready), 32'(!(m_busy || m_done)));
            chk("model out_valid", 32'(out_valid), 32'(m_done));
            if (m_done) begin
                chk("model out_data", 32'(out_data), 32'(m_data));
                chk("model out_mode", 32'(out_mode), 32'(m_mode));
                chk("model out_err", 32'(out_err), 32'(m_err));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_idle(input string nm);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s idle wait: in_ready still %0d after %0d cycles, required 1",
                     nm, in_ready, guard);
        end
    endtask

    // Edge count includes the accept edge.
    task automatic do_req(input logic [1:0] mode, input logic [3:0] x, input logic [7:0] y,
                          input logic [7:0] exp_d, input logic exp_e, input int exp_edges,
                          input string nm);
        int edges;
        wait_idle(nm);
        in_valid = 1'b1;
        in_mode  = mode;
        in_x     = x;
        in_y     = y;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        edges = 1;
        chk({nm, " not early"}, 32'(out_valid || (exp_edges == 1)), 32'(exp_edges == 1));
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({nm, " latency"}, 32'(edges), 32'(exp_edges));
        chk({nm, " data"}, 32'(out_data), 32'(exp_d));
        chk({nm, " err"}, 32'(out_err), 32'(exp_e));
        chk({nm, " mode"}, 32'(out_mode), 32'(mode));
    endtask

    logic [7:0] held;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_mode", 32'(out_mode), 32'd0);
        chk("reset out_err", 32'(out_err), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        do_req(2'd0, 4'd3, 8'd0, 8'd29, 1'b0, 2, "quad x=3");
        do_req(2'd0, 4'h8, 8'd0, 8'hE6, 1'b0, 2, "quad x=-8");
        do_req(2'd1, 4'd5, 8'd0, 8'd120, 1'b0, 5, "fact n=5");
        do_req(2'd1, 4'd6, 8'd0, 8'hD0, 1'b0, 6, "fact n=6");
        do_req(2'd1, 4'd0, 8'd0, 8'd1, 1'b0, 2, "fact n=0");
        do_req(2'd1, 4'd1, 8'd0, 8'd1, 1'b0, 2, "fact n=1");
        do_req(2'd2, 4'd0, 8'd29, 8'd3, 1'b0, 17, "invq y=29");
        do_req(2'd2, 4'd0, 8'hDE, 8'hFA, 1'b0, 17, "invq y=-34");
        do_req(2'd2, 4'd0, 8'd0, 8'd1, 1'b0, 17, "invq y=0");

        // Backpressure: result must hold while the consumer stalls.
        wait_idle("bp");
        out_ready = 1'b0;
        do_req(2'd0, 4'd3, 8'd0, 8'd29, 1'b0, 2, "bp quad");
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp out_data", 32'(out_data), 32'(held));
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);

        // Abort an inverse-quadratic sweep with reset.
        wait_idle("abort");
        in_valid = 1'b1;
        in_mode  = 2'd2;
        in_y     = 8'd29;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        do_req(2'd0, 4'd1, 8'd0, 8'd1, 1'b0, 2, "quad x=1 after abort");

        do_req(2'd3, 4'd5, 8'd7, 8'd0, 1'b1, 2, "reserved");
        do_req(2'd0, 4'h8, 8'd0, 8'hE6, 1'b0, 2, "after reserved");

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bench still running");
        $fatal(1, "watchdog");
    end

endmodule
